// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between NUM_REQ requesters.
// Sequences the converter load/done handshake and guards it with a watchdog.
module bcd_conv_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int BIN_WIDTH  = 32,
  parameter  int NUM_DIGITS = 3,
  parameter  int TIMEOUT    = 256,
  localparam int ID_W       = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][BIN_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                conv_load,
  output logic [BIN_WIDTH-1:0]                conv_bin,
  input  logic [NUM_DIGITS-1:0][3:0]          conv_bcd,
  input  logic                                conv_done,
  output logic                                rsp_valid,
  output logic [ID_W-1:0]                     rsp_id,
  output logic [NUM_DIGITS-1:0][3:0]          rsp_bcd,
  output logic                                rsp_err,
  input  logic                                rsp_ready,
  output logic                                busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

  state_t               state;
  state_t               next_state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      id_reg;
  logic [BIN_WIDTH-1:0] op_reg;
  logic [CNT_W-1:0]     wd_cnt;
  logic [ID_W-1:0]      cand;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 grant;
  logic                 expired;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant    = (state == IDLE) && grant_found && !rst;
  assign expired  = (wd_cnt == CNT_W'(TIMEOUT - 1));
  assign conv_bin = op_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (grant) next_state = LOAD;
      LOAD: next_state = BUSY;
      BUSY: if (conv_done || expired) next_state = RESP;
      RESP: if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[grant_idx] = 1'b1;
  end

  // A done arriving in the expiry cycle takes priority over the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      id_reg    <= '0;
      op_reg    <= '0;
      wd_cnt    <= '0;
      conv_load <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bcd   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      conv_load <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            op_reg    <= req_data[grant_idx];
            id_reg    <= grant_idx;
            rr_ptr    <= grant_idx;
            conv_load <= 1'b1;
          end
        end
        LOAD: wd_cnt <= '0;
        BUSY: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (conv_done) begin
            rsp_bcd <= conv_bcd;
            rsp_err <= 1'b0;
            rsp_id  <= id_reg;
          end else if (expired) begin
            rsp_bcd <= '0;
            rsp_err <= 1'b1;
            rsp_id  <= id_reg;
          end
        end
        default: ;
      endcase
      rsp_valid <= (next_state == RESP);
      busy      <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural converter of programmable latency.
// Expected responses are queued at grant time and compared when the arbiter answers.
module tb_bcd_conv_arbiter;

  localparam int NR = 4;
  localparam int BW = 32;
  localparam int ND = 3;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0][BW-1:0] req_data;
  logic [NR-1:0]        req_ready;
  logic                 conv_load;
  logic [BW-1:0]        conv_bin;
  logic [ND*4-1:0]      conv_bcd;
  logic                 conv_done;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [ND*4-1:0]      rsp_bcd;
  logic                 rsp_err;
  logic                 rsp_ready;
  logic                 busy;

  bcd_conv_arbiter #(.NUM_REQ(NR), .BIN_WIDTH(BW), .NUM_DIGITS(ND), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .conv_load(conv_load), .conv_bin(conv_bin), .conv_bcd(conv_bcd), .conv_done(conv_done),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [11:0] bcd;
    logic        err;
    longint      due;
  } exp_t;

  exp_t        sb[$];
  int          exp_grant[$];
  int          n_checks = 0;
  int          n_errors = 0;
  longint      cycle = 0;
  longint      load_due = -1;
  longint      idle_due = -1;
  longint      last_accept = -1;
  logic [31:0] load_op;
  int          grants_seen = 0;
  int          rsps_seen = 0;
  int          conv_lat = 3;
  logic        conv_dead = 1'b0;
  logic        check_regrant = 1'b0;
  logic        prev_valid = 1'b0;
  logic [1:0]  hold_id;
  logic [11:0] hold_bcd;
  logic        hold_err;
  logic [31:0] exp_op [NR];
  logic [11:0] exp_bcd [NR];
  logic [31:0] m_val;
  int          m_cnt;

  function automatic logic [11:0] to_bcd(input logic [31:0] v);
    logic [11:0] r;
    int t;
    t = int'(v % 1000);
    for (int d = 0; d < 3; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Converter model: done pulses conv_lat cycles after the load cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_val <= '0;
    end else if (conv_load) begin
      m_val <= conv_bin;
      m_cnt <= conv_lat;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign conv_done = !conv_dead && (m_cnt == 1);
  assign conv_bcd  = to_bcd(m_val);

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if ((req_valid & req_ready) != '0) begin
        int g;
        exp_t e;
        g = -1;
        for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) g = i;
        checkOutput("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
        checkOutput("grant_id", 64'(g), (exp_grant.size() != 0) ? 64'(exp_grant.pop_front()) : 64'hFF);
        if (check_regrant) begin
          checkOutput("regrant_cycle", 64'(cycle), 64'(last_accept + 1));
          check_regrant = 1'b0;
        end
        e.id  = g;
        e.err = conv_dead;
        e.bcd = conv_dead ? 12'h000 : exp_bcd[g];
        e.due = cycle + 2 + (conv_dead ? TO : conv_lat);
        sb.push_back(e);
        load_due = cycle + 1;
        load_op  = exp_op[g];
        grants_seen++;
      end
      if (cycle == load_due) begin
        checkOutput("conv_load", 64'(conv_load), 64'd1);
        checkOutput("conv_bin", 64'(conv_bin), 64'(load_op));
      end else if (conv_load) begin
        checkOutput("conv_load_extra", 64'(conv_load), 64'd0);
      end
      if (rsp_valid) begin
        checkOutput("req_ready_in_resp", 64'(req_ready), 64'd0);
        if (!prev_valid) begin
          checkOutput("rsp_latency", 64'(cycle), (sb.size() != 0) ? 64'(sb[0].due) : 64'hFFFF);
          hold_id  = rsp_id;
          hold_bcd = rsp_bcd;
          hold_err = rsp_err;
        end else begin
          checkOutput("hold_id", 64'(rsp_id), 64'(hold_id));
          checkOutput("hold_bcd", 64'(rsp_bcd), 64'(hold_bcd));
          checkOutput("hold_err", 64'(rsp_err), 64'(hold_err));
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
            checkOutput("rsp_bcd", 64'(rsp_bcd), 64'(e.bcd));
            checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
          end
          rsps_seen++;
          idle_due    = cycle + 1;
          last_accept = cycle;
        end
      end
      if (cycle == idle_due) checkOutput("idle_after_accept", 64'(busy), 64'd0);
      prev_valid = rsp_valid;
    end
  end

  task automatic applyStimulus(input int id, input logic [31:0] op, input logic [11:0] bcd);
    int start;
    int k;
    start       = grants_seen;
    req_data[id] = op;
    exp_op[id]   = op;
    exp_bcd[id]  = bcd;
    exp_grant.push_back(id);
    req_valid[id] = 1'b1;
    k = 0;
    while (grants_seen == start && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (grants_seen == start) checkOutput("grant_timeout", 64'(grants_seen), 64'(start + 1));
    req_valid[id] = 1'b0;
  endtask

  task automatic waitResponses(input int target);
    int k;
    k = 0;
    while (rsps_seen < target && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (rsps_seen < target) checkOutput("rsp_timeout", 64'(rsps_seen), 64'(target));
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    checkOutput({pfx, "_conv_load"}, 64'(conv_load), 64'd0);
    checkOutput({pfx, "_conv_bin"}, 64'(conv_bin), 64'd0);
    checkOutput({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({pfx, "_rsp_id"}, 64'(rsp_id), 64'd0);
    checkOutput({pfx, "_rsp_bcd"}, 64'(rsp_bcd), 64'd0);
    checkOutput({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
    checkOutput({pfx, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    sb.delete();
    load_due   = -1;
    idle_due   = -1;
    prev_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [31:0] rr_ops [4];
    logic [11:0] rr_bcd [4];
    rr_ops = '{32'd5, 32'd17, 32'd123, 32'd999};
    rr_bcd = '{12'h005, 12'h017, 12'h123, 12'h999};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #12;
    req_valid = 4'b0001;
    #1;
    checkResetOutputs("reset");
    req_valid = '0;
    #7;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single request");
    conv_lat = 3;
    applyStimulus(0, 32'h0B, 12'h011);
    waitResponses(1);

    $display("[TB] round robin");
    pulseReset();
    for (int i = 0; i < NR; i++) begin
      req_data[i] = rr_ops[i];
      exp_op[i]   = rr_ops[i];
      exp_bcd[i]  = rr_bcd[i];
    end
    for (int i = 0; i < 5; i++) exp_grant.push_back(i % NR);
    req_valid = 4'b1111;
    begin
      int k;
      k = 0;
      while (grants_seen < 6 && k < 400) begin
        @(posedge clk); #1;
        k++;
      end
      if (grants_seen < 6) checkOutput("rr_grant_timeout", 64'(grants_seen), 64'd6);
    end
    req_valid = '0;
    waitResponses(6);

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    applyStimulus(1, 32'd42, 12'h042);
    req_data[3]  = 32'd300;
    exp_op[3]    = 32'd300;
    exp_bcd[3]   = 12'h300;
    exp_grant.push_back(3);
    req_valid[3] = 1'b1;
    begin
      int k;
      k = 0;
      while (!rsp_valid && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      if (!rsp_valid) checkOutput("bp_rsp_timeout", 64'(rsp_valid), 64'd1);
    end
    repeat (10) begin
      @(posedge clk); #1;
    end
    check_regrant = 1'b1;
    rsp_ready     = 1'b1;
    begin
      int k;
      k = 0;
      while (grants_seen < 8 && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      if (grants_seen < 8) checkOutput("bp_regrant_timeout", 64'(grants_seen), 64'd8);
    end
    req_valid[3] = 1'b0;
    waitResponses(8);

    $display("[TB] watchdog");
    conv_dead = 1'b1;
    applyStimulus(2, 32'd7, 12'h007);
    waitResponses(9);
    conv_dead = 1'b0;
    conv_lat  = 8;
    applyStimulus(0, 32'd255, 12'h255);
    waitResponses(10);

    $display("[TB] reset mid-operation");
    conv_lat = 6;
    applyStimulus(1, 32'd77, 12'h077);
    repeat (3) @(posedge clk);
    #3;
    checkOutput("busy_before_reset", 64'(busy), 64'd1);
    rst = 1'b1;
    sb.delete();
    load_due   = -1;
    idle_due   = -1;
    prev_valid = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    conv_lat = 3;
    applyStimulus(2, 32'd456, 12'h456);
    waitResponses(11);
    repeat (3) @(posedge clk);
    #1;

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("grants_left", 64'(exp_grant.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one SumOfNumbers2_10 binary-to-BCD converter between NUM_REQ requesters.
- Arbitrates round-robin and captures the winner's operand.
- Sequences the converter's load/done handshake, then returns the BCD result tagged with the requester index.
- Includes a watchdog so a converter that never completes cannot hang the shared resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- BIN_WIDTH, 32, width of binary operand (matches converter binaryNumberWidth)
- NUM_DIGITS, 3, BCD digits returned (matches converter numberOfDigits)
- TIMEOUT, 256, max cycles spent in BUSY waiting for conv_done (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ x BIN_WIDTH  per-requester operand, packed [NUM_REQ-1:0][BIN_WIDTH-1:0]
- req_ready  out  NUM_REQ  one-hot accept; request i is consumed when req_valid[i] && req_ready[i]
- conv_load  out  1  one-cycle load pulse to converter
- conv_bin  out  BIN_WIDTH  operand to converter, held stable from LOAD until leaving BUSY
- conv_bcd  in  NUM_DIGITS x 4  converter result [NUM_DIGITS-1:0][3:0]
- conv_done  in  1  converter completion (to2_10Sum); result valid in the cycle it is high
- rsp_valid  out  1  response available
- rsp_id  out  $clog2(NUM_REQ)  index of requester served
- rsp_bcd  out  NUM_DIGITS x 4  captured result; all zeros on error
- rsp_err  out  1  1 = watchdog expired, no result
- rsp_ready  in  1  consumer accepts response
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state=IDLE.
  - All outputs are 0: req_ready, conv_load, conv_bin, rsp_valid, rsp_id, rsp_bcd, rsp_err, busy.
  - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-conversion abandons the transaction; no response is produced.
- FSM states: IDLE, LOAD, BUSY, RESP.
- IDLE:
  - Winner is the first set req_valid bit searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - req_ready is 0 in all states other than IDLE.
  - On the clock edge: latch req_data[winner] into op_reg, winner into id_reg, set rr_ptr=winner, go to LOAD.
  - No valid request: stay in IDLE.
- LOAD:
  - conv_load=1 for exactly this cycle; conv_bin=op_reg.
  - Clear the watchdog counter and go to BUSY.
  - conv_done is ignored in LOAD.
- BUSY:
  - Counter increments every cycle.
  - conv_done=1: capture conv_bcd into rsp_bcd, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set rsp_bcd=0, rsp_err=1, go to RESP.
  - conv_done in the same cycle as expiry: done wins, rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_id=id_reg; rsp_bcd and rsp_err are held stable.
  - rsp_ready=1: go to IDLE next cycle. No new grant occurs in that acceptance cycle, so there is no same-cycle re-arbitration.
  - conv_done is ignored in RESP and IDLE.
- Latency (cycle 0 = grant):
  - conv_load in cycle 1.
  - If conv_done arrives in cycle 1+k (k>=1), rsp_valid rises in cycle 2+k.
  - Earliest next grant is 1 cycle after response acceptance.
- Fairness: a continuously requesting input waits at most NUM_REQ-1 transactions.
- Requester changes: req_data/req_valid may change freely except in the grant cycle. A requester dropping req_valid before being granted is simply skipped.
- Outputs are registered except req_ready.
- rsp_id width is 1 when NUM_REQ=2.

Test Plan:
- Single request: reset 20 ns, then req_valid[0]=1 with req_data[0]=0x0B.
  - req_ready[0] pulses for 1 cycle; conv_load pulses 1 cycle later with conv_bin=0x0B.
  - After conv_done: rsp_valid=1, rsp_id=0, rsp_bcd=12'h011, rsp_err=0.
- Round-robin: req_valid=4'b1111 held, with operands 5, 17, 123, 999.
  - Grants occur in order 0,1,2,3,0.
  - Responses are 12'h005, 12'h017, 12'h123, 12'h999 with ids 0..3.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid rises.
  - rsp_valid, rsp_bcd and rsp_id stay stable; no req_ready is asserted; the FSM returns to IDLE 1 cycle after rsp_ready=1.
- Watchdog with TIMEOUT=8: conv_done tied 0.
  - rsp_valid rises 8 cycles after BUSY entry with rsp_err=1 and rsp_bcd=0.
  - A subsequent request with working conv_done returns err=0.
- Reset mid-operation: assert rst while in BUSY.
  - All outputs go to 0 asynchronously and busy=0.
  - After release, req_valid[2] alone is granted and yields a correct response with rsp_id=2.
